// File: rtl/dma_copy_pkg.sv
// Shared definitions for the DMA copy engine: register map, CTRL/status bit
// positions and the transfer state encoding.
package dma_copy_pkg;

   localparam logic [2:0] REG_SRC    = 3'd0;
   localparam logic [2:0] REG_DST    = 3'd1;
   localparam logic [2:0] REG_LEN    = 3'd2;
   localparam logic [2:0] REG_CTRL   = 3'd3;
   localparam logic [2:0] REG_REMAIN = 3'd4;

   localparam int CTRL_START    = 0;
   localparam int CTRL_ABORT    = 1;
   localparam int CTRL_CLR_DONE = 2;
   localparam int CTRL_CLR_ERR  = 3;
   localparam int CTRL_IRQ_EN   = 4;

   localparam int STAT_BUSY       = 0;
   localparam int STAT_ABORT_PEND = 1;
   localparam int STAT_DONE       = 2;
   localparam int STAT_ERR        = 3;
   localparam int STAT_IRQ_EN     = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_CMD  = 2'd1,
      RD_WAIT = 2'd2,
      WR_CMD  = 2'd3
   } state_t;

endpackage

// File: rtl/dma_copy_regs.sv
// Slave-side register window of the DMA copy engine: decode, programmed
// registers, CTRL strobes and the one-cycle read response.
module dma_copy_regs
   import dma_copy_pkg::*;
#(
   parameter int LEN_BITS = 16
) (
   input  logic                clk,
   input  logic                reset_,
   input  logic                cmd_sel,
   input  logic                cmd_valid,
   input  logic                cmd_wr,
   input  logic [11:0]         cmd_addr,
   input  logic [31:0]         cmd_wdata,
   output logic                rsp_ready,
   output logic [31:0]         rsp_rdata,
   input  logic                busy,
   input  logic                done,
   input  logic                err,
   input  logic                abort_pend,
   input  logic [LEN_BITS-1:0] remain,
   output logic [31:0]         src,
   output logic [31:0]         dst,
   output logic [LEN_BITS-1:0] len,
   output logic                irq_en,
   output logic                start,
   output logic                abort,
   output logic                clr_done,
   output logic                clr_err
);

   logic [2:0]  reg_sel;
   logic        wr_en;
   logic        rd_en;
   logic        ctrl_wr;
   logic [31:0] rd_mux;
   logic        unused_addr;

   assign reg_sel     = cmd_addr[4:2];
   assign wr_en       = cmd_valid & cmd_sel & cmd_wr;
   assign rd_en       = cmd_valid & cmd_sel & ~cmd_wr;
   assign ctrl_wr     = wr_en && (reg_sel == REG_CTRL);
   assign unused_addr = ^{cmd_addr[11:5], cmd_addr[1:0]};

   assign start    = ctrl_wr & cmd_wdata[CTRL_START];
   assign abort    = ctrl_wr & cmd_wdata[CTRL_ABORT];
   assign clr_done = ctrl_wr & cmd_wdata[CTRL_CLR_DONE];
   assign clr_err  = ctrl_wr & cmd_wdata[CTRL_CLR_ERR];

   // Transfer parameters are frozen while a copy runs; irq_en stays writable.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         src    <= '0;
         dst    <= '0;
         len    <= '0;
         irq_en <= 1'b0;
      end else if (wr_en) begin
         case (reg_sel)
            REG_SRC:  if (!busy) src <= {cmd_wdata[31:2], 2'b00};
            REG_DST:  if (!busy) dst <= {cmd_wdata[31:2], 2'b00};
            REG_LEN:  if (!busy) len <= cmd_wdata[LEN_BITS-1:0];
            REG_CTRL: irq_en <= cmd_wdata[CTRL_IRQ_EN];
            default:  ;
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_sel)
         REG_SRC:    rd_mux = src;
         REG_DST:    rd_mux = dst;
         REG_LEN:    rd_mux = 32'(len);
         REG_CTRL: begin
            rd_mux[STAT_BUSY]       = busy;
            rd_mux[STAT_ABORT_PEND] = abort_pend;
            rd_mux[STAT_DONE]       = done;
            rd_mux[STAT_ERR]        = err;
            rd_mux[STAT_IRQ_EN]     = irq_en;
         end
         REG_REMAIN: rd_mux = 32'(remain);
         default:    rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         rsp_ready <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         rsp_ready <= rd_en;
         if (rd_en) rsp_rdata <= rd_mux;
      end
   end

endmodule

// File: rtl/dma_copy_engine.sv
// Memory-to-memory word copy engine: register window on the slave port,
// one-word-in-flight read/write sequencer on the master port.
module dma_copy_engine
   import dma_copy_pkg::*;
#(
   parameter int LEN_BITS    = 16,
   parameter int RSP_TIMEOUT = 255,
   parameter int TMO_BITS    = 8
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        mem_cmd_sel,
   input  logic        mem_cmd_valid,
   input  logic        mem_cmd_wr,
   input  logic [11:0] mem_cmd_addr,
   input  logic [31:0] mem_cmd_wdata,
   output logic        mem_rsp_ready,
   output logic [31:0] mem_rsp_rdata,
   output logic        mst_cmd_valid,
   input  logic        mst_cmd_ready,
   output logic        mst_cmd_wr,
   output logic        mst_cmd_instr,
   output logic [31:0] mst_cmd_addr,
   output logic [31:0] mst_cmd_wdata,
   output logic [3:0]  mst_cmd_be,
   input  logic        mst_rsp_ready,
   input  logic [31:0] mst_rsp_rdata,
   output logic        irq
);

   state_t              state;
   state_t              state_nxt;
   logic [31:0]         src;
   logic [31:0]         dst;
   logic [LEN_BITS-1:0] len;
   logic                irq_en;
   logic                start;
   logic                abort;
   logic                clr_done;
   logic                clr_err;
   logic [31:0]         src_ptr;
   logic [31:0]         dst_ptr;
   logic [LEN_BITS-1:0] remain;
   logic [31:0]         data;
   logic [TMO_BITS-1:0] tmo;
   logic                done;
   logic                err;
   logic                abort_pend;
   logic                busy;
   logic                abort_now;
   logic                tmo_hit;
   logic                done_set;
   logic                err_set;

   dma_copy_regs #(.LEN_BITS(LEN_BITS)) u_regs (
      .clk        (clk),
      .reset_     (reset_),
      .cmd_sel    (mem_cmd_sel),
      .cmd_valid  (mem_cmd_valid),
      .cmd_wr     (mem_cmd_wr),
      .cmd_addr   (mem_cmd_addr),
      .cmd_wdata  (mem_cmd_wdata),
      .rsp_ready  (mem_rsp_ready),
      .rsp_rdata  (mem_rsp_rdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .abort_pend (abort_pend),
      .remain     (remain),
      .src        (src),
      .dst        (dst),
      .len        (len),
      .irq_en     (irq_en),
      .start      (start),
      .abort      (abort),
      .clr_done   (clr_done),
      .clr_err    (clr_err)
   );

   assign busy      = (state != IDLE);
   assign abort_now = abort_pend | (abort & busy);
   assign tmo_hit   = (tmo == TMO_BITS'(RSP_TIMEOUT));

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) state <= IDLE;
      else         state <= state_nxt;
   end

   // Abort is only honoured at word boundaries so a raised valid always sees its ready.
   always_comb begin
      state_nxt = state;
      done_set  = 1'b0;
      err_set   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (len != '0) state_nxt = RD_CMD;
               else           done_set  = 1'b1;
            end
         end
         RD_CMD: begin
            if (mst_cmd_ready) state_nxt = RD_WAIT;
         end
         RD_WAIT: begin
            if (mst_rsp_ready) begin
               if (abort_now) begin
                  state_nxt = IDLE;
                  done_set  = 1'b1;
               end else begin
                  state_nxt = WR_CMD;
               end
            end else if (tmo_hit) begin
               state_nxt = IDLE;
               done_set  = 1'b1;
               err_set   = 1'b1;
            end
         end
         WR_CMD: begin
            if (mst_cmd_ready) begin
               if ((remain == LEN_BITS'(1)) || abort_now) begin
                  state_nxt = IDLE;
                  done_set  = 1'b1;
               end else begin
                  state_nxt = RD_CMD;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         src_ptr <= '0;
         dst_ptr <= '0;
         remain  <= '0;
         data    <= '0;
         tmo     <= '0;
      end else begin
         if (state == IDLE && start) begin
            src_ptr <= src;
            dst_ptr <= dst;
            remain  <= len;
         end
         if (state == RD_CMD && mst_cmd_ready) begin
            src_ptr <= src_ptr + 32'd4;
            tmo     <= '0;
         end
         if (state == RD_WAIT) begin
            if (mst_rsp_ready) data <= mst_rsp_rdata;
            else               tmo  <= tmo + TMO_BITS'(1);
         end
         if (state == WR_CMD && mst_cmd_ready) begin
            dst_ptr <= dst_ptr + 32'd4;
            remain  <= remain - LEN_BITS'(1);
         end
      end
   end

   // A set from the sequencer beats a software clear landing on the same edge.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         done       <= 1'b0;
         err        <= 1'b0;
         abort_pend <= 1'b0;
      end else begin
         if (done_set)      done <= 1'b1;
         else if (clr_done) done <= 1'b0;
         if (err_set)       err  <= 1'b1;
         else if (clr_err)  err  <= 1'b0;
         if (busy && state_nxt == IDLE) abort_pend <= 1'b0;
         else if (abort && busy)        abort_pend <= 1'b1;
      end
   end

   assign mst_cmd_valid = (state == RD_CMD) || (state == WR_CMD);
   assign mst_cmd_wr    = (state == WR_CMD);
   assign mst_cmd_instr = 1'b0;
   assign mst_cmd_addr  = (state == WR_CMD) ? dst_ptr : src_ptr;
   assign mst_cmd_wdata = data;
   assign mst_cmd_be    = 4'hf;
   assign irq           = done & irq_en;

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine with a simple bus-slave memory model.
module tb_dma_copy_engine;

   logic        clk;
   logic        reset_;
   logic        mem_cmd_sel;
   logic        mem_cmd_valid;
   logic        mem_cmd_wr;
   logic [11:0] mem_cmd_addr;
   logic [31:0] mem_cmd_wdata;
   logic        mem_rsp_ready;
   logic [31:0] mem_rsp_rdata;
   logic        mst_cmd_valid;
   logic        mst_cmd_ready;
   logic        mst_cmd_wr;
   logic        mst_cmd_instr;
   logic [31:0] mst_cmd_addr;
   logic [31:0] mst_cmd_wdata;
   logic [3:0]  mst_cmd_be;
   logic        mst_rsp_ready;
   logic [31:0] mst_rsp_rdata;
   logic        irq;

   dma_copy_engine dut (
      .clk           (clk),
      .reset_        (reset_),
      .mem_cmd_sel   (mem_cmd_sel),
      .mem_cmd_valid (mem_cmd_valid),
      .mem_cmd_wr    (mem_cmd_wr),
      .mem_cmd_addr  (mem_cmd_addr),
      .mem_cmd_wdata (mem_cmd_wdata),
      .mem_rsp_ready (mem_rsp_ready),
      .mem_rsp_rdata (mem_rsp_rdata),
      .mst_cmd_valid (mst_cmd_valid),
      .mst_cmd_ready (mst_cmd_ready),
      .mst_cmd_wr    (mst_cmd_wr),
      .mst_cmd_instr (mst_cmd_instr),
      .mst_cmd_addr  (mst_cmd_addr),
      .mst_cmd_wdata (mst_cmd_wdata),
      .mst_cmd_be    (mst_cmd_be),
      .mst_rsp_ready (mst_rsp_ready),
      .mst_rsp_rdata (mst_rsp_rdata),
      .irq           (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Owned by the stimulus process
   logic [31:0] src_mem [0:1023];
   int          stall_cycles = 0;
   int          withhold_idx = -1;
   logic        inject_rsp   = 1'b0;
   int          n_assert     = 0;
   int          n_fail       = 0;

   // Owned by the slave model
   logic [31:0] rd_addr_log [0:63];
   logic [31:0] wr_addr_log [0:63];
   logic [31:0] wr_data_log [0:63];
   int          rd_cnt    = 0;
   int          wr_cnt    = 0;
   int          valid_cnt = 0;
   int          stab_err  = 0;
   int          side_err  = 0;

   // Slave memory: ready after stall_cycles of valid, read data one cycle after accept.
   initial begin
      int          wait_cnt;
      logic        prev_pend;
      logic        rsp_pending;
      logic [31:0] rsp_data;
      logic [31:0] p_addr;
      logic [31:0] p_wdata;
      logic        p_wr;
      wait_cnt      = 0;
      prev_pend     = 1'b0;
      rsp_pending   = 1'b0;
      rsp_data      = '0;
      p_addr        = '0;
      p_wdata       = '0;
      p_wr          = 1'b0;
      mst_cmd_ready = 1'b0;
      mst_rsp_ready = 1'b0;
      mst_rsp_rdata = '0;
      forever begin
         @(negedge clk);
         mst_rsp_ready = rsp_pending | inject_rsp;
         mst_rsp_rdata = inject_rsp ? 32'hDEAD_BEEF : rsp_data;
         rsp_pending   = 1'b0;
         if (prev_pend && !(mst_cmd_valid === 1'b1 && mst_cmd_addr === p_addr &&
                            mst_cmd_wdata === p_wdata && mst_cmd_wr === p_wr))
            stab_err++;
         if (mst_cmd_valid && (mst_cmd_be !== 4'hf || mst_cmd_instr !== 1'b0))
            side_err++;
         if (mst_cmd_valid) begin
            valid_cnt++;
            if (wait_cnt >= stall_cycles) begin
               mst_cmd_ready = 1'b1;
               wait_cnt      = 0;
               prev_pend     = 1'b0;
               if (mst_cmd_wr) begin
                  if (wr_cnt < 64) begin
                     wr_addr_log[wr_cnt] = mst_cmd_addr;
                     wr_data_log[wr_cnt] = mst_cmd_wdata;
                  end
                  wr_cnt++;
               end else begin
                  if (rd_cnt < 64) rd_addr_log[rd_cnt] = mst_cmd_addr;
                  rsp_pending = (rd_cnt != withhold_idx);
                  rsp_data    = src_mem[mst_cmd_addr[11:2]];
                  rd_cnt++;
               end
            end else begin
               mst_cmd_ready = 1'b0;
               wait_cnt++;
               prev_pend = 1'b1;
               p_addr    = mst_cmd_addr;
               p_wdata   = mst_cmd_wdata;
               p_wr      = mst_cmd_wr;
            end
         end else begin
            mst_cmd_ready = 1'b0;
            prev_pend     = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic reg_write(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      mem_cmd_sel   = 1'b1;
      mem_cmd_valid = 1'b1;
      mem_cmd_wr    = 1'b1;
      mem_cmd_addr  = a;
      mem_cmd_wdata = d;
      @(negedge clk);
      mem_cmd_sel   = 1'b0;
      mem_cmd_valid = 1'b0;
      mem_cmd_wr    = 1'b0;
      check("wr_no_rsp", 32'(mem_rsp_ready), 32'd0);
   endtask

   task automatic reg_read(input string tag, input logic [11:0] a, input logic [31:0] exp);
      logic [31:0] d;
      @(negedge clk);
      mem_cmd_sel   = 1'b1;
      mem_cmd_valid = 1'b1;
      mem_cmd_wr    = 1'b0;
      mem_cmd_addr  = a;
      @(negedge clk);
      mem_cmd_sel   = 1'b0;
      mem_cmd_valid = 1'b0;
      check({tag, "_rsp_pulse"}, 32'(mem_rsp_ready), 32'd1);
      d = mem_rsp_rdata;
      check(tag, d, exp);
      @(negedge clk);
      check({tag, "_rsp_single"}, 32'(mem_rsp_ready), 32'd0);
   endtask

   initial begin
      int rb;
      int wb;
      int vb;
      for (int i = 0; i < 1024; i++) src_mem[i] = '0;
      src_mem[32'h100 >> 2] = 32'h0000_000A;
      src_mem[32'h104 >> 2] = 32'h0000_000B;
      src_mem[32'h108 >> 2] = 32'h0000_000C;
      src_mem[32'h10C >> 2] = 32'h0000_000D;
      reset_        = 1'b0;
      mem_cmd_sel   = 1'b0;
      mem_cmd_valid = 1'b0;
      mem_cmd_wr    = 1'b0;
      mem_cmd_addr  = '0;
      mem_cmd_wdata = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mst_valid", 32'(mst_cmd_valid), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_rsp_ready", 32'(mem_rsp_ready), 32'd0);
      reset_ = 1'b1;
      reg_read("rst_src", 12'h000, 32'h0);
      reg_read("rst_dst", 12'h004, 32'h0);
      reg_read("rst_len", 12'h008, 32'h0);
      reg_read("rst_ctrl", 12'h00C, 32'h0);
      reg_read("rst_remain", 12'h010, 32'h0);

      // Register access: alignment masking, unmapped offsets
      reg_write(12'h000, 32'h0000_0123);
      reg_read("src_align", 12'h000, 32'h0000_0120);
      reg_write(12'h004, 32'h0000_0207);
      reg_read("dst_align", 12'h004, 32'h0000_0204);
      reg_write(12'h01C, 32'hFFFF_FFFF);
      reg_read("unmapped_1c", 12'h01C, 32'h0);
      reg_read("unmapped_14", 12'h014, 32'h0);

      // Basic 3-word copy with irq
      reg_write(12'h000, 32'h0000_0100);
      reg_write(12'h004, 32'h0000_0200);
      reg_write(12'h008, 32'd3);
      reg_read("t1_len", 12'h008, 32'd3);
      rb = rd_cnt; wb = wr_cnt;
      reg_write(12'h00C, 32'h11);
      repeat (40) @(negedge clk);
      check("t1_rd_cnt", 32'(rd_cnt - rb), 32'd3);
      check("t1_wr_cnt", 32'(wr_cnt - wb), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t1_rd_addr%0d", i), rd_addr_log[rb+i], 32'h100 + 32'(4*i));
         check($sformatf("t1_wr_addr%0d", i), wr_addr_log[wb+i], 32'h200 + 32'(4*i));
         check($sformatf("t1_wr_data%0d", i), wr_data_log[wb+i], 32'hA + 32'(i));
      end
      check("t1_irq", 32'(irq), 32'd1);
      reg_read("t1_ctrl", 12'h00C, 32'h14);
      reg_read("t1_remain", 12'h010, 32'h0);
      reg_read("t1_src_kept", 12'h000, 32'h100);
      reg_write(12'h00C, 32'h04);
      check("t1_irq_clr", 32'(irq), 32'd0);
      reg_read("t1_ctrl_clr", 12'h00C, 32'h0);

      // Same copy with 5 cycles of backpressure on every command
      stall_cycles = 5;
      reg_write(12'h004, 32'h0000_0300);
      rb = rd_cnt; wb = wr_cnt;
      reg_write(12'h00C, 32'h01);
      repeat (100) @(negedge clk);
      check("t2_rd_cnt", 32'(rd_cnt - rb), 32'd3);
      check("t2_wr_cnt", 32'(wr_cnt - wb), 32'd3);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_rd_addr%0d", i), rd_addr_log[rb+i], 32'h100 + 32'(4*i));
         check($sformatf("t2_wr_addr%0d", i), wr_addr_log[wb+i], 32'h300 + 32'(4*i));
         check($sformatf("t2_wr_data%0d", i), wr_data_log[wb+i], 32'hA + 32'(i));
      end
      check("t2_stable", 32'(stab_err), 32'd0);
      reg_read("t2_ctrl", 12'h00C, 32'h4);
      reg_read("t2_remain", 12'h010, 32'h0);
      reg_write(12'h00C, 32'h04);
      stall_cycles = 0;

      // LEN=0: immediate done, no bus traffic; set beats a same-cycle clear
      reg_write(12'h008, 32'd0);
      vb = valid_cnt;
      check("t3_irq_before", 32'(irq), 32'd0);
      reg_write(12'h00C, 32'h11);
      check("t3_irq_next", 32'(irq), 32'd1);
      reg_read("t3_ctrl_irq", 12'h00C, 32'h14);
      reg_write(12'h00C, 32'h05);
      reg_read("t3_ctrl_setwins", 12'h00C, 32'h4);
      check("t3_irq_off", 32'(irq), 32'd0);
      repeat (5) @(negedge clk);
      check("t3_no_valid", 32'(valid_cnt - vb), 32'd0);
      reg_write(12'h00C, 32'h04);

      // Read response timeout on word 2 of 4; busy-time LEN write ignored
      reg_write(12'h008, 32'd4);
      reg_write(12'h004, 32'h0000_0500);
      rb = rd_cnt; wb = wr_cnt;
      withhold_idx = rd_cnt + 1;
      reg_write(12'h00C, 32'h01);
      repeat (20) @(negedge clk);
      reg_write(12'h008, 32'd7);
      reg_read("t4_len_busy", 12'h008, 32'd4);
      reg_read("t4_remain_mid", 12'h010, 32'd3);
      reg_read("t4_ctrl_busy", 12'h00C, 32'h1);
      repeat (300) @(negedge clk);
      reg_read("t4_ctrl_tmo", 12'h00C, 32'hC);
      reg_read("t4_remain", 12'h010, 32'd3);
      check("t4_wr_cnt", 32'(wr_cnt - wb), 32'd1);
      check("t4_wr_addr", wr_addr_log[wb], 32'h500);
      check("t4_wr_data", wr_data_log[wb], 32'hA);
      vb = valid_cnt;
      @(posedge clk);
      inject_rsp = 1'b1;
      @(posedge clk);
      inject_rsp = 1'b0;
      repeat (5) @(negedge clk);
      reg_read("t4_ctrl_late", 12'h00C, 32'hC);
      check("t4_late_no_valid", 32'(valid_cnt - vb), 32'd0);
      check("t4_rd_cnt", 32'(rd_cnt - rb), 32'd2);
      check("t4_wr_cnt_late", 32'(wr_cnt - wb), 32'd1);
      reg_write(12'h00C, 32'h08);
      reg_read("t4_ctrl_clr_err", 12'h00C, 32'h4);
      reg_write(12'h00C, 32'h04);
      reg_read("t4_ctrl_clr_done", 12'h00C, 32'h0);

      // Abort while waiting for the first read response of LEN=4
      reg_write(12'h004, 32'h0000_0600);
      rb = rd_cnt; wb = wr_cnt;
      withhold_idx = rd_cnt;
      reg_write(12'h00C, 32'h01);
      repeat (10) @(negedge clk);
      reg_write(12'h00C, 32'h02);
      reg_read("t5_ctrl_pend", 12'h00C, 32'h3);
      @(posedge clk);
      inject_rsp = 1'b1;
      @(posedge clk);
      inject_rsp = 1'b0;
      repeat (5) @(negedge clk);
      reg_read("t5_ctrl_done", 12'h00C, 32'h4);
      reg_read("t5_remain", 12'h010, 32'd4);
      check("t5_wr_cnt", 32'(wr_cnt - wb), 32'd0);
      check("t5_rd_cnt", 32'(rd_cnt - rb), 32'd1);
      withhold_idx = -1;
      check("side_fields", 32'(side_err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
